matrix_ctrl: RTL

Access controller for the 1024×1024×32-bit matrix datapath. It arbitrates single-word read/write requests from two requesters and translates each (row, col) into the datapath's one-hot RAM select, 16-bit RAM address, write data and per-RAM write enable. It captures read data from the datapath's asynchronous output and can optionally run a whole-matrix clear sequence. It sits between the host-load and compute engines and the matrix datapath.

---
 rtl/matrix_ctrl.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/matrix_ctrl.sv
// Round-robin access controller for the 1024x1024x32 matrix datapath; 1-cycle ACCESS, read data 2 cycles after accept.
// No response backpressure; readys only in IDLE. Optional whole-matrix clear under MATRIX_CTRL_CLEAR_EN.
module matrix_ctrl #(
  parameter logic [31:0] CLEAR_DATA = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic        req0_we,
  input  logic [9:0]  req0_row,
  input  logic [9:0]  req0_col,
  input  logic [31:0] req0_wdata,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic        req1_we,
  input  logic [9:0]  req1_row,
  input  logic [9:0]  req1_col,
  input  logic [31:0] req1_wdata,
  output logic        rsp0_valid,
  output logic        rsp1_valid,
  output logic [31:0] rsp_data,
  input  logic        clear_start,
  output logic        clear_busy,
  output logic [15:0] ram_sel,
  output logic [15:0] a,
  output logic [31:0] din,
  output logic [15:0] we,
  input  logic [31:0] dout
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_CLEAR} state_t;

  state_t      state_q, state_d;
  logic        last_q, last_d;
  logic        lat_we_q, lat_we_d;
  logic        lat_id_q, lat_id_d;
  logic [15:0] ram_sel_q, ram_sel_d;
  logic [15:0] a_q, a_d;
  logic [31:0] din_q, din_d;
  logic [15:0] we_q, we_d;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic [1:0]  rsp_vld_q, rsp_vld_d;

  logic        clear_go;
  logic        gnt0, gnt1, accept;
  logic        g_we;
  logic [9:0]  g_row, g_col;
  logic [31:0] g_wdata;

`ifdef MATRIX_CTRL_CLEAR_EN
  logic [15:0] cnt_q, cnt_d;
  assign clear_go   = clear_start;
  assign clear_busy = (state_q == S_CLEAR);
`else
  logic unused_clear;
  assign unused_clear = clear_start ^ (^CLEAR_DATA);
  assign clear_go     = 1'b0;
  assign clear_busy   = 1'b0;
`endif

  // last_q names the previous winner; the other requester wins a tie.
  assign gnt0   = (state_q == S_IDLE) && !RST && !clear_go && req0_valid && (!req1_valid || last_q);
  assign gnt1   = (state_q == S_IDLE) && !RST && !clear_go && req1_valid && (!req0_valid || !last_q);
  assign accept = gnt0 || gnt1;

  assign g_we    = gnt1 ? req1_we    : req0_we;
  assign g_row   = gnt1 ? req1_row   : req0_row;
  assign g_col   = gnt1 ? req1_col   : req0_col;
  assign g_wdata = gnt1 ? req1_wdata : req0_wdata;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= S_IDLE;
      last_q     <= 1'b1;
      lat_we_q   <= 1'b0;
      lat_id_q   <= 1'b0;
      ram_sel_q  <= '0;
      a_q        <= '0;
      din_q      <= '0;
      we_q       <= '0;
      rsp_data_q <= '0;
      rsp_vld_q  <= '0;
`ifdef MATRIX_CTRL_CLEAR_EN
      cnt_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      lat_we_q   <= lat_we_d;
      lat_id_q   <= lat_id_d;
      ram_sel_q  <= ram_sel_d;
      a_q        <= a_d;
      din_q      <= din_d;
      we_q       <= we_d;
      rsp_data_q <= rsp_data_d;
      rsp_vld_q  <= rsp_vld_d;
`ifdef MATRIX_CTRL_CLEAR_EN
      cnt_q      <= cnt_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (clear_go)    state_d = S_CLEAR;
        else if (accept) state_d = S_ACCESS;
      end
      S_ACCESS: state_d = S_IDLE;
`ifdef MATRIX_CTRL_CLEAR_EN
      S_CLEAR: if (cnt_q == 16'hFFFF) state_d = S_IDLE;
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    last_d     = last_q;
    lat_we_d   = lat_we_q;
    lat_id_d   = lat_id_q;
    ram_sel_d  = ram_sel_q;
    a_d        = a_q;
    din_d      = din_q;
    we_d       = '0;
    rsp_data_d = rsp_data_q;
    rsp_vld_d  = '0;
`ifdef MATRIX_CTRL_CLEAR_EN
    cnt_d      = cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (clear_go) begin
`ifdef MATRIX_CTRL_CLEAR_EN
          cnt_d     = '0;
          a_d       = '0;
          we_d      = 16'hFFFF;
          din_d     = CLEAR_DATA;
          ram_sel_d = 16'h0001;
`endif
        end else if (accept) begin
          last_d    = gnt1;
          lat_we_d  = g_we;
          lat_id_d  = gnt1;
          ram_sel_d = 16'd1 << g_row[9:6];
          a_d       = {g_row[5:0], g_col};
          if (g_we) begin
            din_d = g_wdata;
            we_d  = 16'd1 << g_row[9:6];
          end
        end
      end
      S_ACCESS: begin
        if (!lat_we_q) begin
          rsp_data_d          = dout;
          rsp_vld_d[lat_id_q] = 1'b1;
        end
      end
`ifdef MATRIX_CTRL_CLEAR_EN
      S_CLEAR: begin
        if (cnt_q != 16'hFFFF) begin
          cnt_d = cnt_q + 16'd1;
          a_d   = cnt_q + 16'd1;
          we_d  = 16'hFFFF;
        end
      end
`endif
      default: ;
    endcase
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
  assign rsp0_valid = rsp_vld_q[0];
  assign rsp1_valid = rsp_vld_q[1];
  assign rsp_data   = rsp_data_q;
  assign ram_sel    = ram_sel_q;
  assign a          = a_q;
  assign din        = din_q;
  assign we         = we_q;

endmodule
